// File: rtl/motor_cmd_sched.sv
// Per-frame dual-motor command scheduler: arbitrates estop/obstacle/nav sources,
// slew-limits each motor level once per frame and inserts a neutral dwell before reversals.
module motor_cmd_sched #(
    parameter int unsigned FRAME_CYCLES   = 1200000,
    parameter int unsigned RAMP_STEP      = 1,
    parameter int unsigned HOLD_FRAMES    = 2,
    parameter int unsigned TIMEOUT_FRAMES = 25
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] NAV_CMD1,
    input  logic [4:0] NAV_CMD2,
    input  logic       NAV_VALID,
    output logic       NAV_ACK,
    input  logic [4:0] OBS_CMD1,
    input  logic [4:0] OBS_CMD2,
    input  logic       OBS_VALID,
    input  logic       ESTOP,
    output logic [4:0] MC1,
    output logic [4:0] MC2,
    output logic       FRAME_TICK,
    output logic [1:0] SRC,
    output logic       TIMEOUT
);

    localparam int unsigned CNT_W  = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int unsigned WD_W   = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_FRAMES);
    localparam logic [WD_W-1:0]   WD_PRE   = WD_W'(TIMEOUT_FRAMES - 1);
    localparam logic [5:0]        STEP     = 6'(RAMP_STEP);
    localparam logic              HOLD_EN  = (HOLD_FRAMES > 0);

    localparam logic [1:0] SRC_NAV   = 2'b00;
    localparam logic [1:0] SRC_OBS   = 2'b01;
    localparam logic [1:0] SRC_ESTOP = 2'b10;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_DWELL = 1'b1;

    localparam logic [4:0] MC_NEUTRAL = 5'b00001;

    // Command word to signed level: fwd p -> +(p+1), rev p -> -(p+1), else 0.
    function automatic logic signed [4:0] cmd_to_lvl(input logic [4:0] cmd);
        logic [4:0] mag;
        mag = {2'b00, cmd[4:2]} + 5'd1;
        case (cmd[1:0])
            2'b00:   return mag;
            2'b10:   return -mag;
            default: return 5'sd0;
        endcase
    endfunction

    // Signed level back to the pulse generator command word; -L-1 is ~L.
    function automatic logic [4:0] lvl_to_mc(input logic signed [4:0] lvl);
        if (lvl == 5'sd0)
            return MC_NEUTRAL;
        else if (!lvl[4])
            return {lvl[2:0] - 3'd1, 2'b00};
        else
            return {~lvl[2:0], 2'b10};
    endfunction

    // One slew step toward tgt, stopping at zero rather than crossing it.
    function automatic logic signed [4:0] ramp_next(input logic signed [4:0] lvl,
                                                    input logic signed [4:0] tgt);
        logic [5:0] diff;
        logic [5:0] mag;
        logic [5:0] stp;
        logic [5:0] nxt;
        diff = {tgt[4], tgt} - {lvl[4], lvl};
        mag  = diff[5] ? (6'd0 - diff) : diff;
        stp  = (mag < STEP) ? mag : STEP;
        nxt  = diff[5] ? ({lvl[4], lvl} - stp) : ({lvl[4], lvl} + stp);
        if (!lvl[4] && (lvl != 5'sd0) && nxt[5])
            nxt = 6'd0;
        else if (lvl[4] && !nxt[5] && (nxt != 6'd0))
            nxt = 6'd0;
        return nxt[4:0];
    endfunction

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              tick_q;
    logic [1:0]        src_q;
    logic              ack_q;
    logic [WD_W-1:0]   wd_q;
    logic              to_q;
    logic signed [4:0] nav_tgt_q [2];
    logic signed [4:0] obs_tgt_q [2];
    logic signed [4:0] tgt       [2];

    logic signed [4:0]  lvl_q  [2];
    logic signed [4:0]  lvl_d  [2];
    logic signed [4:0]  step_l [2];
    logic               st_q   [2];
    logic               st_d   [2];
    logic [HOLD_W-1:0]  dw_q   [2];
    logic [HOLD_W-1:0]  dw_d   [2];
    logic [4:0]         mc_q   [2];
    logic [4:0]         mc_d   [2];

    logic [4:0] nav_cmd [2];
    logic [4:0] obs_cmd [2];

    assign nav_cmd[0] = NAV_CMD1;
    assign nav_cmd[1] = NAV_CMD2;
    assign obs_cmd[0] = OBS_CMD1;
    assign obs_cmd[1] = OBS_CMD2;

    assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    // Frame timing, source select, target capture and nav watchdog.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            src_q  <= SRC_NAV;
            ack_q  <= 1'b0;
            wd_q   <= '0;
            to_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                nav_tgt_q[i] <= 5'sd0;
                obs_tgt_q[i] <= 5'sd0;
            end
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_LAST);
            ack_q  <= NAV_VALID;

            if (ESTOP)
                src_q <= SRC_ESTOP;
            else if (OBS_VALID)
                src_q <= SRC_OBS;
            else
                src_q <= SRC_NAV;

            if (OBS_VALID) begin
                for (int i = 0; i < 2; i++)
                    obs_tgt_q[i] <= cmd_to_lvl(obs_cmd[i]);
            end

            if (NAV_VALID) begin
                for (int i = 0; i < 2; i++)
                    nav_tgt_q[i] <= cmd_to_lvl(nav_cmd[i]);
                wd_q <= '0;
                to_q <= 1'b0;
            end else if (tick_q && (wd_q != WD_MAX)) begin
                wd_q <= wd_q + 1'b1;
                if (wd_q == WD_PRE) begin
                    for (int i = 0; i < 2; i++)
                        nav_tgt_q[i] <= 5'sd0;
                    to_q <= 1'b1;
                end
            end
        end
    end

    // Effective per-motor target from the registered source.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            tgt[m] = 5'sd0;
            case (src_q)
                SRC_NAV: tgt[m] = nav_tgt_q[m];
                SRC_OBS: tgt[m] = obs_tgt_q[m];
                default: tgt[m] = 5'sd0;
            endcase
        end
    end

    // Ramp/dwell next-state; estop overrides frame timing.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            lvl_d[m]  = lvl_q[m];
            st_d[m]   = st_q[m];
            dw_d[m]   = dw_q[m];
            step_l[m] = ramp_next(lvl_q[m], tgt[m]);

            if (ESTOP) begin
                lvl_d[m] = 5'sd0;
                st_d[m]  = ST_RUN;
                dw_d[m]  = '0;
            end else if (tick_q) begin
                case (st_q[m])
                    ST_RUN: begin
                        if (lvl_q[m] != tgt[m]) begin
                            lvl_d[m] = step_l[m];
                            if (HOLD_EN && (step_l[m] == 5'sd0) &&
                                (lvl_q[m] != 5'sd0) && (tgt[m] != 5'sd0)) begin
                                st_d[m] = ST_DWELL;
                                dw_d[m] = HOLD_INIT;
                            end
                        end
                    end
                    ST_DWELL: begin
                        lvl_d[m] = 5'sd0;
                        if (dw_q[m] == '0)
                            st_d[m] = ST_RUN;
                        else
                            dw_d[m] = dw_q[m] - 1'b1;
                    end
                    default: st_d[m] = ST_RUN;
                endcase
            end

            mc_d[m] = lvl_to_mc(lvl_d[m]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int m = 0; m < 2; m++) begin
                lvl_q[m] <= 5'sd0;
                st_q[m]  <= ST_RUN;
                dw_q[m]  <= '0;
                mc_q[m]  <= MC_NEUTRAL;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                lvl_q[m] <= lvl_d[m];
                st_q[m]  <= st_d[m];
                dw_q[m]  <= dw_d[m];
                mc_q[m]  <= mc_d[m];
            end
        end
    end

    assign MC1        = mc_q[0];
    assign MC2        = mc_q[1];
    assign FRAME_TICK = tick_q;
    assign SRC        = src_q;
    assign NAV_ACK    = ack_q;
    assign TIMEOUT    = to_q;

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Directed bench for motor_cmd_sched: ramp, reversal dwell, priority, watchdog,
// coincident capture and async reset. A second instance uses a short watchdog.
`timescale 1ns/1ps
module tb_motor_cmd_sched;

    localparam int unsigned FC = 100;
    localparam logic [4:0] WD_EXP [8] = '{5'b00000, 5'b00100, 5'b01000, 5'b01000,
                                          5'b01000, 5'b00100, 5'b00000, 5'b00001};

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [4:0] NAV_CMD1 = 5'b00001;
    logic [4:0] NAV_CMD2 = 5'b00001;
    logic       NAV_VALID = 1'b0;
    logic [4:0] OBS_CMD1 = 5'b00001;
    logic [4:0] OBS_CMD2 = 5'b00001;
    logic       OBS_VALID = 1'b0;
    logic       ESTOP = 1'b0;

    logic       NAV_ACK, FRAME_TICK, TIMEOUT;
    logic [4:0] MC1, MC2;
    logic [1:0] SRC;
    logic       nav_ack_w, frame_tick_w, timeout_w;
    logic [4:0] mc1_w, mc2_w;
    logic [1:0] src_w;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    motor_cmd_sched #(.FRAME_CYCLES(FC), .RAMP_STEP(1), .HOLD_FRAMES(2), .TIMEOUT_FRAMES(25)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .NAV_CMD1(NAV_CMD1), .NAV_CMD2(NAV_CMD2), .NAV_VALID(NAV_VALID), .NAV_ACK(NAV_ACK),
        .OBS_CMD1(OBS_CMD1), .OBS_CMD2(OBS_CMD2), .OBS_VALID(OBS_VALID), .ESTOP(ESTOP),
        .MC1(MC1), .MC2(MC2), .FRAME_TICK(FRAME_TICK), .SRC(SRC), .TIMEOUT(TIMEOUT)
    );

    motor_cmd_sched #(.FRAME_CYCLES(FC), .RAMP_STEP(1), .HOLD_FRAMES(2), .TIMEOUT_FRAMES(5)) dut_wd (
        .CLK(CLK), .RST_N(RST_N),
        .NAV_CMD1(NAV_CMD1), .NAV_CMD2(NAV_CMD2), .NAV_VALID(NAV_VALID), .NAV_ACK(nav_ack_w),
        .OBS_CMD1(OBS_CMD1), .OBS_CMD2(OBS_CMD2), .OBS_VALID(OBS_VALID), .ESTOP(ESTOP),
        .MC1(mc1_w), .MC2(mc2_w), .FRAME_TICK(frame_tick_w), .SRC(src_w), .TIMEOUT(timeout_w)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] exp_mc(input int l);
        if (l > 0) return {3'(l - 1), 2'b00};
        if (l < 0) return {3'(-l - 1), 2'b10};
        return 5'b00001;
    endfunction

    task automatic after_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        NAV_VALID = 1'b0; OBS_VALID = 1'b0; ESTOP = 1'b0;
        NAV_CMD1 = 5'b00001; NAV_CMD2 = 5'b00001;
        OBS_CMD1 = 5'b00001; OBS_CMD2 = 5'b00001;
        #20;
        @(negedge CLK);
        RST_N = 1'b1;
        after_edge();
    endtask

    task automatic nav_send(input logic [4:0] c1, input logic [4:0] c2);
        NAV_CMD1 = c1;
        NAV_CMD2 = c2;
        NAV_VALID = 1'b1;
        after_edge();
        NAV_VALID = 1'b0;
        check("nav_ack", 8'(NAV_ACK), 8'd1);
    endtask

    // Returns 1 ns after the next tick edge.
    task automatic wait_tick();
        for (int i = 0; i < FC + 2; i++) begin
            @(negedge CLK);
            if (FRAME_TICK) break;
        end
        check("tick_seen", 8'(FRAME_TICK), 8'd1);
        after_edge();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lv;

        // Reset state
        #12;
        check("rst_mc1", 8'(MC1), 8'b00001);
        check("rst_mc2", 8'(MC2), 8'b00001);
        check("rst_src", 8'(SRC), 8'd0);
        check("rst_timeout", 8'(TIMEOUT), 8'd0);
        check("rst_ack", 8'(NAV_ACK), 8'd0);
        check("rst_tick", 8'(FRAME_TICK), 8'd0);
        do_reset();

        // Ramp up to fwd p7
        nav_send(5'b11100, 5'b00001);
        after_edge();
        check("ack_drop", 8'(NAV_ACK), 8'd0);
        check("pre_tick_mc1", 8'(MC1), 8'b00001);
        for (int k = 1; k <= 8; k++) begin
            wait_tick();
            check($sformatf("ramp_t%0d", k), 8'(MC1), 8'(exp_mc(k)));
        end
        check("ramp_mc2", 8'(MC2), 8'b00001);

        // Reversal to rev p7 with dwell
        after_edge();
        nav_send(5'b11110, 5'b00001);
        for (int k = 1; k <= 19; k++) begin
            wait_tick();
            lv = (k <= 8) ? 8 - k : (k <= 11) ? 0 : -(k - 11);
            check($sformatf("rev_t%0d", k), 8'(MC1), 8'(exp_mc(lv)));
        end

        // Priority: obs over nav, estop over both
        do_reset();
        nav_send(5'b01100, 5'b00001);
        for (int k = 0; k < 4; k++) wait_tick();
        check("prio_nav", 8'(MC1), 8'b01100);
        repeat (5) after_edge();
        OBS_CMD1 = 5'b00001; OBS_CMD2 = 5'b00001; OBS_VALID = 1'b1;
        after_edge();
        check("prio_src_obs", 8'(SRC), 8'b01);
        wait_tick();
        check("prio_obs_step", 8'(MC1), 8'b01000);
        repeat (10) after_edge();
        ESTOP = 1'b1;
        after_edge();
        check("estop_mc1", 8'(MC1), 8'b00001);
        check("estop_mc2", 8'(MC2), 8'b00001);
        check("estop_src", 8'(SRC), 8'b10);
        wait_tick();
        check("estop_hold", 8'(MC1), 8'b00001);
        repeat (10) after_edge();
        ESTOP = 1'b0; OBS_VALID = 1'b0;
        after_edge();
        check("release_src", 8'(SRC), 8'b00);
        wait_tick();
        check("release_t1", 8'(MC1), 8'b00000);
        for (int k = 0; k < 3; k++) wait_tick();
        check("release_t4", 8'(MC1), 8'b01100);

        // Watchdog on the short-timeout instance
        do_reset();
        nav_send(5'b01000, 5'b00001);
        for (int k = 1; k <= 8; k++) begin
            wait_tick();
            check($sformatf("wd_to_t%0d", k), 8'(timeout_w), (k >= 5) ? 8'd1 : 8'd0);
            check($sformatf("wd_mc_t%0d", k), 8'(mc1_w), 8'(WD_EXP[k-1]));
        end
        check("wd_long_timeout", 8'(TIMEOUT), 8'd0);
        after_edge();
        nav_send(5'b01000, 5'b00001);
        check("wd_clear", 8'(timeout_w), 8'd0);

        // NAV_VALID coincident with FRAME_TICK
        do_reset();
        nav_send(5'b00100, 5'b00001);
        for (int k = 0; k < 3; k++) wait_tick();
        check("sim_steady", 8'(MC1), 8'b00100);
        for (int i = 0; i < FC + 2; i++) begin
            @(negedge CLK);
            if (FRAME_TICK) break;
        end
        check("sim_tick_seen", 8'(FRAME_TICK), 8'd1);
        NAV_CMD1 = 5'b00001;
        NAV_VALID = 1'b1;
        after_edge();
        NAV_VALID = 1'b0;
        check("sim_unchanged", 8'(MC1), 8'b00100);
        check("sim_ack", 8'(NAV_ACK), 8'd1);
        wait_tick();
        check("sim_follow", 8'(MC1), 8'b00000);

        // Async reset mid-ramp with obstacle source active
        OBS_CMD1 = 5'b11100; OBS_VALID = 1'b1;
        after_edge();
        check("ar_src_pre", 8'(SRC), 8'b01);
        #3;
        RST_N = 1'b0;
        #1;
        check("ar_mc1", 8'(MC1), 8'b00001);
        check("ar_mc2", 8'(MC2), 8'b00001);
        check("ar_src", 8'(SRC), 8'b00);
        check("ar_ack", 8'(NAV_ACK), 8'd0);
        OBS_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (98) after_edge();
        check("ar_frame_pre", 8'(FRAME_TICK), 8'd0);
        after_edge();
        check("ar_frame_tick", 8'(FRAME_TICK), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
